// File: rtl/glb_stream_pkg.sv
// Shared GLB stream definitions for the sink and the future source-side blocks.
package glb_stream_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } sink_state_t;

endpackage

// File: rtl/glb_sink_mem.sv
// Capture memory: one synchronous write port, one registered read port.
module glb_sink_mem
  import glb_stream_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/glb_stream_sink.sv
// Ready/valid sink for the GLB stream: captures TX_SIZE words, counts and checksums them.
module glb_stream_sink
  import glb_stream_pkg::*;
#(
  parameter int TX_SIZE      = 32,
  parameter int DEPTH        = 1024,
  parameter int STALL_PERIOD = 0,
  localparam int CNT_W = (TX_SIZE < 1) ? 1 : $clog2(TX_SIZE + 1),
  localparam int AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] checksum,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int SC_W = (STALL_PERIOD < 2) ? 1 : $clog2(STALL_PERIOD);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'((STALL_PERIOD >= 2) ? STALL_PERIOD - 1 : 0);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'((TX_SIZE >= 1) ? TX_SIZE - 1 : 0);

  if (STALL_PERIOD == 1 || STALL_PERIOD < 0) begin : g_bad_stall
    $error("glb_stream_sink: STALL_PERIOD must be 0 or >= 2");
  end
  if (TX_SIZE < 0 || TX_SIZE > DEPTH) begin : g_bad_size
    $error("glb_stream_sink: TX_SIZE must lie in 0..DEPTH");
  end

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  sink_state_t       state;
  logic [SC_W-1:0]   stall_q;
  logic [AW-1:0]     wr_ptr;
  logic              stall_slot;
  logic              accept;

  // ready comes only from registered state so there is no valid->ready path.
  assign stall_slot = (STALL_PERIOD >= 2) && (stall_q == SC_LAST);
  assign ready      = (state == RECV) && !stall_slot;
  assign done       = (state == DONE);
  assign accept     = valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      checksum <= '0;
      stall_q  <= '0;
      wr_ptr   <= '0;
    end else begin
      case (state)
        RECV: begin
          if (STALL_PERIOD >= 2) stall_q <= stall_slot ? '0 : stall_q + SC_W'(1);
          if (accept) begin
            count    <= count + CNT_W'(1);
            checksum <= csum_add(checksum, data);
            wr_ptr   <= wr_ptr + AW'(1);
            if (count == TX_LAST) state <= DONE;
          end
        end
        default: begin
          if (start) begin
            count    <= '0;
            checksum <= '0;
            stall_q  <= '0;
            wr_ptr   <= '0;
            state    <= (TX_SIZE == 0) ? DONE : RECV;
          end
        end
      endcase
    end
  end

  glb_sink_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_glb_stream_sink.sv
// Scoreboard bench for glb_stream_sink across four parameter sets sharing one stream.
module tb_glb_stream_sink;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  start;
  logic [15:0] data;
  logic        valid;
  logic [9:0]  rd_addr;

  logic [3:0]  rdy, dn;
  logic [5:0]  c0, c4;
  logic [1:0]  cw;
  logic [0:0]  cz;
  logic [15:0] s0, s4, sw, sz, r0, r4, rw, rz;

  glb_stream_sink #(.TX_SIZE(32), .DEPTH(1024), .STALL_PERIOD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .data(data), .valid(valid),
    .ready(rdy[0]), .done(dn[0]), .count(c0), .checksum(s0), .rd_addr(rd_addr), .rd_data(r0));
  glb_stream_sink #(.TX_SIZE(32), .DEPTH(1024), .STALL_PERIOD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .data(data), .valid(valid),
    .ready(rdy[1]), .done(dn[1]), .count(c4), .checksum(s4), .rd_addr(rd_addr), .rd_data(r4));
  glb_stream_sink #(.TX_SIZE(2), .DEPTH(1024), .STALL_PERIOD(0)) uw (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .data(data), .valid(valid),
    .ready(rdy[2]), .done(dn[2]), .count(cw), .checksum(sw), .rd_addr(rd_addr), .rd_data(rw));
  glb_stream_sink #(.TX_SIZE(0), .DEPTH(1024), .STALL_PERIOD(0)) uz (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .data(data), .valid(valid),
    .ready(rdy[3]), .done(dn[3]), .count(cz), .checksum(sz), .rd_addr(rd_addr), .rd_data(rz));

  int          sel = 0;
  logic        rdy_sel, dn_sel;
  logic [15:0] cnt_sel, sum_sel, rd_sel;

  always_comb begin
    rdy_sel = 1'b0; dn_sel = 1'b0; cnt_sel = '0; sum_sel = '0; rd_sel = '0;
    case (sel)
      0: begin rdy_sel = rdy[0]; dn_sel = dn[0]; cnt_sel = 16'(c0); sum_sel = s0; rd_sel = r0; end
      1: begin rdy_sel = rdy[1]; dn_sel = dn[1]; cnt_sel = 16'(c4); sum_sel = s4; rd_sel = r4; end
      2: begin rdy_sel = rdy[2]; dn_sel = dn[2]; cnt_sel = 16'(cw); sum_sel = sw; rd_sel = rw; end
      3: begin rdy_sel = rdy[3]; dn_sel = dn[3]; cnt_sel = 16'(cz); sum_sel = sz; rd_sel = rz; end
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] sum;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] words[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, start_cyc = 0;
  bit          armed = 1'b0;
  int          stalls = 0, rz_hi = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected end-of-transfer result when the selected sink reports done.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (armed && sel == 1 && !rdy_sel && !dn_sel) stalls++;
    if (sel == 3 && rdy_sel) rz_hi++;
    if (armed && dn_sel && sb.size() != 0) begin
      e = sb.pop_front();
      check("done_count",    32'(cnt_sel), 32'(e.cnt));
      check("done_checksum", 32'(sum_sel), 32'(e.sum));
      check("done_latency",  32'(cyc - start_cyc), 32'(e.lat));
      armed = 1'b0;
    end
  end

  task automatic pulse_start(input int s, input bit push, input logic [15:0] ec,
                             input logic [15:0] es, input int el);
    sel = s;
    if (push) sb.push_back('{cnt: ec, sum: es, lat: el});
    start[s] = 1'b1;
    @(posedge clk); #1;
    start     = '0;
    start_cyc = cyc;
    armed     = push;
  endtask

  task automatic drive(input int n);
    bit r;
    int guard;
    for (int i = 0; i < n; i++) begin
      data  = words[i];
      valid = 1'b1;
      guard = 0;
      r     = 1'b0;
      while (!r && guard < 20) begin
        @(negedge clk);
        r = rdy_sel;
        @(posedge clk); #1;
        guard++;
      end
      if (!r) begin
        check("beat_timeout", 32'(i), 32'(n));
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic wait_sb();
    int i = 0;
    while (sb.size() != 0 && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    armed = 1'b0;
  endtask

  task automatic readback(input string name, input logic [9:0] addr, input logic [15:0] exp);
    rd_addr = addr;
    @(posedge clk); #1;
    check(name, 32'(rd_sel), 32'(exp));
  endtask

  task automatic fill(input logic [15:0] base, input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(base + 16'(i));
  endtask

  initial begin
    rst_n = 1'b0; start = '0; valid = 1'b0; data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle with valid held and no start.
    sel = 0; valid = 1'b1; data = 16'h1234;
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", 32'(rdy_sel), 32'd0);
      check("idle_done",  32'(dn_sel),  32'd0);
      check("idle_count", 32'(cnt_sel), 32'd0);
    end
    @(posedge clk); #1;
    valid = 1'b0;

    // No stalls: 0x0000..0x001F.
    fill(16'h0000, 32);
    pulse_start(0, 1'b1, 16'd32, 16'h01F0, 33);
    drive(32);
    wait_sb();
    readback("rb_nostall_5",  10'd5,  16'h0005);
    readback("rb_nostall_31", 10'd31, 16'h001F);

    // Ready dropped every 4th RECV cycle.
    stalls = 0;
    pulse_start(1, 1'b1, 16'd32, 16'h01F0, 43);
    drive(32);
    wait_sb();
    check("stall_cycles", 32'(stalls), 32'd10);
    readback("rb_stall_17", 10'd17, 16'h0011);

    // Checksum wraps modulo 2^16.
    words.delete();
    words.push_back(16'hFFFF);
    words.push_back(16'h0003);
    pulse_start(2, 1'b1, 16'd2, 16'h0002, 3);
    drive(2);
    wait_sb();
    readback("rb_wrap_0", 10'd0, 16'hFFFF);
    readback("rb_wrap_1", 10'd1, 16'h0003);

    // Reset in the middle of a transfer, then a fresh one.
    fill(16'h0000, 32);
    pulse_start(0, 1'b0, 16'd0, 16'h0000, 0);
    drive(10);
    check("pre_reset_count", 32'(cnt_sel), 32'd10);
    rst_n = 1'b0;
    #1;
    check("rst_ready",    32'(rdy_sel), 32'd0);
    check("rst_done",     32'(dn_sel),  32'd0);
    check("rst_count",    32'(cnt_sel), 32'd0);
    check("rst_checksum", 32'(sum_sel), 32'd0);
    check("rst_rd_data",  32'(rd_sel),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill(16'h0100, 32);
    pulse_start(0, 1'b1, 16'd32, 16'h21F0, 33);
    drive(32);
    wait_sb();
    readback("rb_fresh_5", 10'd5, 16'h0105);

    // Zero-length transfer, twice.
    rz_hi = 0;
    pulse_start(3, 1'b1, 16'd0, 16'h0000, 1);
    wait_sb();
    pulse_start(3, 1'b1, 16'd0, 16'h0000, 1);
    wait_sb();
    check("tx0_ready_high", 32'(rz_hi), 32'd0);
    check("tx0_done_held",  32'(dn_sel), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
